// File: rtl/mc_control_unit_pkg.sv
// Shared types for the multi-cycle control unit: ALU operation encoding.
package mc_control_unit_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

endpackage

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/HALTED FSM,
// instruction register, immediate extension and retired-instruction counter.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int CNT_W    = 32,
    parameter int LINK_REG = 31
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [31:0]       instr,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              alu_zero,
    output logic              iREN,
    output logic              dREN,
    output logic              dWEN,
    output logic              ir_wr,
    output logic              pc_wr,
    output logic [1:0]        pc_src,
    output logic              reg_wr,
    output logic [4:0]        wsel,
    output logic              regdst,
    output logic              memtoreg,
    output logic              link,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output aluop_t            aluop,
    output logic              alusrc,
    output logic [WORD_W-1:0] ext_imm,
    output logic              halt,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALTED = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic [5:0] op, funct;
    logic       dec_legal, dec_alusrc, is_rtype, is_branch, is_jr;
    aluop_t     dec_aluop;

    assign op       = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign is_rtype = (op == OP_RTYPE);
    assign is_jr    = is_rtype && (funct == F_JR);
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign retired  = retired_q;

    // Instruction decode: legality, ALU operation and operand select.
    always_comb begin
        dec_legal  = 1'b1;
        dec_aluop  = ALU_ADD;
        dec_alusrc = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec_alusrc = 1'b0;
                case (funct)
                    F_SLL:          dec_aluop = ALU_SLL;
                    F_SRL:          dec_aluop = ALU_SRL;
                    F_JR:           dec_aluop = ALU_ADD;
                    F_ADD, F_ADDU:  dec_aluop = ALU_ADD;
                    F_SUB, F_SUBU:  dec_aluop = ALU_SUB;
                    F_AND:          dec_aluop = ALU_AND;
                    F_OR:           dec_aluop = ALU_OR;
                    F_XOR:          dec_aluop = ALU_XOR;
                    F_NOR:          dec_aluop = ALU_NOR;
                    F_SLT:          dec_aluop = ALU_SLT;
                    F_SLTU:         dec_aluop = ALU_SLTU;
                    default:        dec_legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_HALT:      dec_alusrc = 1'b0;
            OP_BEQ, OP_BNE: begin
                dec_aluop  = ALU_SUB;
                dec_alusrc = 1'b0;
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: dec_aluop = ALU_ADD;
            OP_SLTI:                    dec_aluop = ALU_SLT;
            OP_SLTIU:                   dec_aluop = ALU_SLTU;
            OP_ANDI:                    dec_aluop = ALU_AND;
            OP_ORI, OP_LUI:             dec_aluop = ALU_OR;
            OP_XORI:                    dec_aluop = ALU_XOR;
            default: begin
                dec_legal  = 1'b0;
                dec_alusrc = 1'b0;
            end
        endcase
    end

    // Immediate extension from the latched instruction.
    always_comb begin
        ext_imm = WORD_W'(signed'(ir_q[15:0]));
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext_imm = WORD_W'(ir_q[15:0]);
            OP_LUI:                   ext_imm = WORD_W'({ir_q[15:0], 16'h0000});
            OP_RTYPE: if (funct == F_SLL || funct == F_SRL) ext_imm = WORD_W'(ir_q[10:6]);
            default: ;
        endcase
    end

    // Next-state and control outputs; everything is forced low while reset is held.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        retire   = 1'b0;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = 2'd0;
        reg_wr   = 1'b0;
        wsel     = 5'd0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        link     = 1'b0;
        aluop    = ALU_SLL;
        alusrc   = 1'b0;
        halt     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                iREN = 1'b1;
                if (ihit) begin
                    ir_wr   = 1'b1;
                    pc_wr   = 1'b1;
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALTED;
                end else if (!dec_legal) begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_J) begin
                    pc_wr   = 1'b1;
                    pc_src  = 2'd2;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_JAL) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                aluop  = dec_aluop;
                alusrc = dec_alusrc;
                if (is_branch) begin
                    // BNE is taken on a nonzero difference, BEQ on zero.
                    if ((op == OP_BEQ) == alu_zero) begin
                        pc_wr  = 1'b1;
                        pc_src = 2'd1;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jr) begin
                    pc_wr   = 1'b1;
                    pc_src  = 2'd3;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dREN = (op == OP_LW);
                dWEN = (op == OP_SW);
                if (dhit) begin
                    if (op == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_wr   = 1'b1;
                memtoreg = (op == OP_LW);
                if (op == OP_JAL) begin
                    // The jump is taken here so the link write sees PC+4.
                    wsel   = LINK_IDX;
                    link   = 1'b1;
                    pc_wr  = 1'b1;
                    pc_src = 2'd2;
                end else if (is_rtype) begin
                    wsel   = ir_q[15:11];
                    regdst = 1'b1;
                end else begin
                    wsel   = ir_q[20:16];
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALTED: halt = 1'b1;
            default:  state_d = S_FETCH;
        endcase
        if (!nRST) begin
            iREN    = 1'b0;
            ir_wr   = 1'b0;
            pc_wr   = 1'b0;
            pc_src  = 2'd0;
            dREN    = 1'b0;
            dWEN    = 1'b0;
            reg_wr  = 1'b0;
            wsel    = 5'd0;
            regdst  = 1'b0;
            memtoreg = 1'b0;
            link    = 1'b0;
            aluop   = ALU_SLL;
            alusrc  = 1'b0;
            halt    = 1'b0;
            illegal = 1'b0;
        end
    end

    assign retired_d = retire ? retired_q + 1'b1 : retired_q;

    // State, instruction register and retire counter.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed self-checking bench for mc_control_unit (CNT_W=4 to reach counter wrap).
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] instr = '0;
    logic        ihit = 1'b0, dhit = 1'b0, alu_zero = 1'b0;
    logic        iREN, dREN, dWEN, ir_wr, pc_wr, reg_wr, regdst, memtoreg, link;
    logic        alusrc, halt, illegal;
    logic [1:0]  pc_src;
    logic [4:0]  wsel, rs, rt;
    aluop_t      aluop;
    logic [31:0] ext_imm;
    logic [3:0]  retired;

    int          n_chk = 0, n_err = 0;
    logic [3:0]  exp_ret = '0;

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    mc_control_unit #(.WORD_W(32), .CNT_W(4), .LINK_REG(31)) dut (
        .CLK(CLK), .nRST(nRST), .instr(instr), .ihit(ihit), .dhit(dhit),
        .alu_zero(alu_zero), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src), .reg_wr(reg_wr),
        .wsel(wsel), .regdst(regdst), .memtoreg(memtoreg), .link(link),
        .rs(rs), .rt(rt), .aluop(aluop), .alusrc(alusrc), .ext_imm(ext_imm),
        .halt(halt), .illegal(illegal), .retired(retired)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [4:0] sh,
                                          input logic [5:0] f);
        return {6'h00, s, t, d, sh, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    // FETCH cycle with ihit; afterwards ihit stays high with a HALT word as noise.
    task automatic fetch(input logic [31:0] w);
        ihit = 1'b1; instr = w; #1;
        chk("fetch_iren", iREN, 1);
        chk("fetch_irwr", ir_wr, 1);
        chk("fetch_pcwr", pc_wr, 1);
        chk("fetch_pcsrc", pc_src, 0);
        cyc();
        instr = HALT_W;
    endtask

    // Back in FETCH after a retirement.
    task automatic back(input string tag);
        ihit = 1'b0; dhit = 1'b0; alu_zero = 1'b0; #1;
        chk({tag, "_iren"}, iREN, 1);
        chk({tag, "_ret"}, retired, exp_ret);
    endtask

    task automatic run_alu(input string tag, input logic [31:0] w, input aluop_t eop,
                           input logic esrc, input logic [31:0] eimm,
                           input logic [4:0] ewsel, input logic edst);
        fetch(w); #1;
        chk({tag, "_imm"}, ext_imm, eimm);
        chk({tag, "_irwr_ign"}, ir_wr, 0);
        chk({tag, "_rs"}, rs, w[25:21]);
        cyc(); #1;
        chk({tag, "_aluop"}, aluop, eop);
        chk({tag, "_alusrc"}, alusrc, esrc);
        chk({tag, "_exwr"}, reg_wr, 0);
        cyc(); #1;
        chk({tag, "_regwr"}, reg_wr, 1);
        chk({tag, "_wsel"}, wsel, ewsel);
        chk({tag, "_regdst"}, regdst, edst);
        chk({tag, "_m2r"}, memtoreg, 0);
        chk({tag, "_rt"}, rt, w[20:16]);
        exp_ret++;
        cyc();
        back(tag);
    endtask

    task automatic run_br(input string tag, input logic [31:0] w, input logic az,
                          input logic epcwr, input logic [1:0] epcsrc);
        fetch(w); #1;
        chk({tag, "_dec_pcwr"}, pc_wr, 0);
        cyc();
        alu_zero = az; #1;
        chk({tag, "_pcwr"}, pc_wr, epcwr);
        chk({tag, "_pcsrc"}, pc_src, epcsrc);
        chk({tag, "_alusrc"}, alusrc, 0);
        exp_ret++;
        cyc();
        back(tag);
    endtask

    task automatic run_ill(input string tag, input logic [31:0] w);
        fetch(w); #1;
        chk({tag, "_ill"}, illegal, 1);
        chk({tag, "_pcwr"}, pc_wr, 0);
        exp_ret++;
        cyc();
        back(tag);
        chk({tag, "_ill_pulse"}, illegal, 0);
    endtask

    initial begin
        // Reset: all outputs low, even with ihit asserted.
        ihit = 1'b1; instr = rtype(1, 2, 3, 0, 6'h21);
        cyc(); cyc(); #1;
        chk("rst_iren", iREN, 0);
        chk("rst_irwr", ir_wr, 0);
        chk("rst_pcwr", pc_wr, 0);
        chk("rst_halt", halt, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_ret", retired, 0);
        chk("rst_imm", ext_imm, 0);
        chk("rst_rs", rs, 0);
        ihit = 1'b0;
        cyc();
        nRST = 1'b1;
        back("rel");

        run_alu("addu", rtype(1, 2, 3, 0, 6'h21), ALU_ADD, 1'b0, 32'h0000_1821, 5'd3, 1'b1);
        run_alu("ori",  itype(6'h0D, 4, 5, 16'h8001), ALU_OR, 1'b1, 32'h0000_8001, 5'd5, 1'b0);
        run_alu("addi", itype(6'h08, 8, 9, 16'h8001), ALU_ADD, 1'b1, 32'hFFFF_8001, 5'd9, 1'b0);
        run_alu("lui",  itype(6'h0F, 0, 10, 16'h1234), ALU_OR, 1'b1, 32'h1234_0000, 5'd10, 1'b0);
        run_alu("sll",  rtype(0, 2, 11, 5, 6'h00), ALU_SLL, 1'b0, 32'h0000_0005, 5'd11, 1'b1);

        // LW with dhit three cycles late: 4 MEM cycles, 8 in total.
        fetch(itype(6'h23, 6, 7, 16'h0004)); #1;
        chk("lw_imm", ext_imm, 32'h4);
        cyc(); #1;
        chk("lw_aluop", aluop, ALU_ADD);
        chk("lw_alusrc", alusrc, 1);
        chk("lw_ex_dren", dREN, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            dhit = (k == 3); #1;
            chk("lw_dren", dREN, 1);
            chk("lw_dwen", dWEN, 0);
            cyc();
        end
        dhit = 1'b0; #1;
        chk("lw_m2r", memtoreg, 1);
        chk("lw_regwr", reg_wr, 1);
        chk("lw_wsel", wsel, 7);
        chk("lw_wb_dren", dREN, 0);
        exp_ret++;
        cyc();
        back("lw");

        // SW zero-wait, dhit also high in EXEC (ignored there).
        fetch(itype(6'h2B, 6, 7, 16'h0008)); #1;
        cyc();
        dhit = 1'b1; #1;
        chk("sw_alusrc", alusrc, 1);
        chk("sw_ex_dwen", dWEN, 0);
        cyc(); #1;
        chk("sw_dwen", dWEN, 1);
        chk("sw_dren", dREN, 0);
        chk("sw_regwr", reg_wr, 0);
        exp_ret++;
        cyc();
        back("sw");

        run_br("beq_t",  itype(6'h04, 1, 2, 16'h0010), 1'b1, 1'b1, 2'd1);
        run_br("beq_nt", itype(6'h04, 1, 2, 16'h0010), 1'b0, 1'b0, 2'd0);
        run_br("bne_t",  itype(6'h05, 1, 2, 16'h0010), 1'b0, 1'b1, 2'd1);
        run_br("jr",     rtype(31, 0, 0, 0, 6'h08),    1'b0, 1'b1, 2'd3);

        // J retires from DECODE.
        fetch({6'h02, 26'h0000010}); #1;
        chk("j_pcwr", pc_wr, 1);
        chk("j_pcsrc", pc_src, 2);
        exp_ret++;
        cyc();
        back("j");

        // JAL writes the link register in its third cycle.
        fetch({6'h03, 26'h0000020}); #1;
        chk("jal_dec_regwr", reg_wr, 0);
        cyc(); #1;
        chk("jal_wsel", wsel, 31);
        chk("jal_link", link, 1);
        chk("jal_regwr", reg_wr, 1);
        exp_ret++;
        cyc();
        back("jal");

        run_ill("ill_op", {6'h3E, 26'h0});
        run_ill("ill_fn", rtype(1, 2, 3, 0, 6'h3F));
        chk("ret_full", retired, 4'hF);

        // Sixteenth retirement wraps the 4-bit counter.
        run_alu("slt", rtype(1, 2, 12, 0, 6'h2A), ALU_SLT, 1'b0, 32'h0000_602A, 5'd12, 1'b1);
        chk("ret_wrap", retired, 4'h0);

        // Reset mid-MEM drops dREN immediately.
        fetch(itype(6'h23, 1, 2, 16'h0)); #1;
        cyc(); cyc(); #1;
        chk("rmem_dren_pre", dREN, 1);
        nRST = 1'b0; #1;
        chk("rmem_dren", dREN, 0);
        chk("rmem_iren", iREN, 0);
        exp_ret = '0;
        cyc();
        nRST = 1'b1;
        back("rmem");

        // Reset mid-WB drops reg_wr without retiring.
        fetch(rtype(1, 2, 3, 0, 6'h21)); #1;
        cyc(); cyc(); #1;
        chk("rwb_regwr_pre", reg_wr, 1);
        nRST = 1'b0; #1;
        chk("rwb_regwr", reg_wr, 0);
        chk("rwb_ret", retired, 0);
        cyc();
        nRST = 1'b1;
        back("rwb");

        // HALT: sticky, ihit ignored, counter frozen.
        fetch({6'h02, 26'h0}); #1;
        exp_ret++;
        cyc();
        back("pre_halt");
        fetch(HALT_W); #1;
        chk("halt_dec", halt, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            ihit = 1'b1; instr = rtype(1, 2, 3, 0, 6'h21); #1;
            chk("halt_on", halt, 1);
            chk("halt_iren", iREN, 0);
            chk("halt_irwr", ir_wr, 0);
            chk("halt_ret", retired, exp_ret);
            cyc();
        end
        ihit = 1'b0;
        nRST = 1'b0; #1;
        chk("halt_rst", halt, 0);
        cyc();
        nRST = 1'b1;
        exp_ret = '0;
        back("post_halt");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
